sync_fifo_ovw: RTL and testbench

Parametrised single-clock circular FIFO. It succeeds the UART receive buffer and generalises width, depth and full-policy (overwrite-oldest or drop-newest). Adds a registered read handshake with valid, occupancy count, almost-full/almost-empty thresholds, flush, and sticky overflow/underflow error flags. Sits between the UART RX deserialiser (write side) and the core's MMIO read path (read side), both in the `clk` domain.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_mem.sv | 31 +++
 rtl/sync_fifo_ovw_chk.sv | 18 +
 rtl/sync_fifo_ovw.sv | 178 +++++++++++++++++
 tb/tb_sync_fifo_ovw.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the overwrite-capable synchronous FIFO.
package fifo_pkg;

    localparam int unsigned MAX_WIDTH = 1024;
    localparam logic [MAX_WIDTH-1:0] EMPTY_VALUE_ALL_ONES = '1;

    // Where rd_data currently comes from; lets rd_data hold without a second data register.
    typedef enum logic [1:0] {
        RD_SRC_RESET = 2'd0,
        RD_SRC_MEM   = 2'd1,
        RD_SRC_EMPTY = 2'd2
    } rd_src_e;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        if (ptr >= depth - 32'd1) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage: synchronous write port, registered read-first read port, no reset.
module fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Read-first: a pop and a push to the same slot (full FIFO) returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ovw_chk.sv
// Simulation-only invariants on the FIFO control state.
module sync_fifo_ovw_chk #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 5,
    parameter int unsigned PW    = 4
) (
    input logic          clk,
    input logic          reset,
    input logic [CW-1:0] count,
    input logic [PW-1:0] wr_ptr,
    input logic [PW-1:0] rd_ptr
);

    a_count_bound: assert property (@(posedge clk) disable iff (!reset) count <= CW'(DEPTH));
    a_wr_ptr_bound: assert property (@(posedge clk) disable iff (!reset) wr_ptr <= PW'(DEPTH - 1));
    a_rd_ptr_bound: assert property (@(posedge clk) disable iff (!reset) rd_ptr <= PW'(DEPTH - 1));

endmodule

// File: rtl/sync_fifo_ovw.sv
// Single-clock circular FIFO with selectable full policy, registered read handshake,
// occupancy/threshold flags, flush and sticky error flags.
module sync_fifo_ovw
    import fifo_pkg::*;
#(
    parameter int unsigned     WIDTH       = 32,
    parameter int unsigned     DEPTH       = 16,
    parameter bit              OVERWRITE   = 1'b1,
    parameter int unsigned     AF_LEVEL    = DEPTH - 2,
    parameter int unsigned     AE_LEVEL    = 1,
    parameter logic [WIDTH-1:0] EMPTY_VALUE = EMPTY_VALUE_ALL_ONES[WIDTH-1:0],
    localparam int unsigned    CW          = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    rd_src_e          rd_src_q, rd_src_d;

    logic             is_empty_s, is_full_s;
    logic             pop_s, grow_s, ovf_set_s, unf_set_s;
    logic             mem_we_s, mem_re_s;
    logic [WIDTH-1:0] mem_rdata_s;

    // Next-state for pointers, occupancy, read handshake and error flags.
    always_comb begin
        is_empty_s  = (count_q == CW'(0));
        is_full_s   = (count_q == CW'(DEPTH));
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_src_d    = rd_src_q;
        rd_valid_d  = 1'b0;
        pop_s       = 1'b0;
        grow_s      = 1'b0;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (rd_en) begin
                if (is_empty_s) begin
                    rd_src_d  = RD_SRC_EMPTY;
                    unf_set_s = 1'b1;
                end else begin
                    pop_s      = 1'b1;
                    mem_re_s   = 1'b1;
                    rd_src_d   = RD_SRC_MEM;
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
                end
            end else begin
                rd_src_d = rd_src_q;
            end

            // A concurrent pop always frees a slot, so only a lone write can hit a full FIFO.
            if (wr_en) begin
                if (!is_full_s || pop_s) begin
                    mem_we_s = 1'b1;
                    grow_s   = 1'b1;
                    wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
                end else if (OVERWRITE) begin
                    mem_we_s  = 1'b1;
                    ovf_set_s = 1'b1;
                    wr_ptr_d  = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
                    rd_ptr_d  = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
                end else begin
                    ovf_set_s = 1'b1;
                end
            end else begin
                mem_we_s = 1'b0;
            end

            if (grow_s && !pop_s) begin
                count_d = count_q + CW'(1);
            end else if (pop_s && !grow_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
        end

        overflow_d  = (clr_err ? 1'b0 : overflow_q)  | ovf_set_s;
        underflow_d = (clr_err ? 1'b0 : underflow_q) | unf_set_s;
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_src_q    <= RD_SRC_RESET;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_src_q    <= rd_src_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (mem_re_s),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata_s)
    );

    // Output data select between registered sources.
    always_comb begin
        case (rd_src_q)
            RD_SRC_MEM:   rd_data = mem_rdata_s;
            RD_SRC_EMPTY: rd_data = EMPTY_VALUE;
            default:      rd_data = '0;
        endcase
    end

    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign empty        = (count_q == CW'(0));
    assign full         = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    sync_fifo_ovw_chk #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .PW    (PW)
    ) u_chk (
        .clk    (clk),
        .reset  (reset),
        .count  (count_q),
        .wr_ptr (wr_ptr_q),
        .rd_ptr (rd_ptr_q)
    );

endmodule

// File: tb/tb_sync_fifo_ovw.sv
// Directed bench: three FIFO variants share stimulus and are checked against a list model.
module tb_sync_fifo_ovw;

    localparam int NDUT = 3;
    localparam int DEP [NDUT] = '{32'd16, 32'd16, 32'd5};
    localparam bit OVW [NDUT] = '{1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        rd_en = 1'b0;
    logic        clr_err = 1'b0;

    logic [31:0] o_data [NDUT];
    logic        o_val [NDUT];
    logic        o_emp [NDUT];
    logic        o_full [NDUT];
    logic        o_ae [NDUT];
    logic        o_af [NDUT];
    logic        o_ovf [NDUT];
    logic        o_unf [NDUT];
    logic [4:0]  cnt0, cnt1;
    logic [2:0]  cnt2;
    int          o_cnt [NDUT];

    assign o_cnt[0] = int'(cnt0);
    assign o_cnt[1] = int'(cnt1);
    assign o_cnt[2] = int'(cnt2);

    // Reference model: each FIFO is an ordered list, index 0 = oldest.
    logic [31:0] mdat [NDUT][16];
    int          msz [NDUT];
    logic [31:0] mrd [NDUT];
    logic        mval [NDUT];
    logic        movf [NDUT];
    logic        munf [NDUT];

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_ovw #(.WIDTH(32), .DEPTH(16), .OVERWRITE(1'b1)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(o_data[0]), .rd_valid(o_val[0]), .count(cnt0),
        .empty(o_emp[0]), .full(o_full[0]), .almost_empty(o_ae[0]), .almost_full(o_af[0]),
        .overflow(o_ovf[0]), .underflow(o_unf[0]), .clr_err(clr_err));

    sync_fifo_ovw #(.WIDTH(32), .DEPTH(16), .OVERWRITE(1'b0)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(o_data[1]), .rd_valid(o_val[1]), .count(cnt1),
        .empty(o_emp[1]), .full(o_full[1]), .almost_empty(o_ae[1]), .almost_full(o_af[1]),
        .overflow(o_ovf[1]), .underflow(o_unf[1]), .clr_err(clr_err));

    sync_fifo_ovw #(.WIDTH(32), .DEPTH(5), .OVERWRITE(1'b1)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(o_data[2]), .rd_valid(o_val[2]), .count(cnt2),
        .empty(o_emp[2]), .full(o_full[2]), .almost_empty(o_ae[2]), .almost_full(o_af[2]),
        .overflow(o_ovf[2]), .underflow(o_unf[2]), .clr_err(clr_err));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            msz[k]  = 0;
            mrd[k]  = 32'd0;
            mval[k] = 1'b0;
            movf[k] = 1'b0;
            munf[k] = 1'b0;
        end
    endtask

    task automatic model_pop_front(input int k);
        for (int i = 0; i < 15; i++) mdat[k][i] = mdat[k][i+1];
        msz[k] = msz[k] - 1;
    endtask

    task automatic model_step();
        bit ovf_set, unf_set;
        if (!reset) begin
            model_reset();
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                ovf_set = 1'b0;
                unf_set = 1'b0;
                if (flush) begin
                    msz[k]  = 0;
                    mval[k] = 1'b0;
                end else begin
                    mval[k] = 1'b0;
                    if (rd_en) begin
                        if (msz[k] > 0) begin
                            mrd[k]  = mdat[k][0];
                            mval[k] = 1'b1;
                            model_pop_front(k);
                        end else begin
                            mrd[k]  = 32'hFFFF_FFFF;
                            unf_set = 1'b1;
                        end
                    end
                    if (wr_en) begin
                        if (msz[k] < DEP[k]) begin
                            mdat[k][msz[k]] = wr_data;
                            msz[k] = msz[k] + 1;
                        end else begin
                            ovf_set = 1'b1;
                            if (OVW[k]) begin
                                model_pop_front(k);
                                mdat[k][msz[k]] = wr_data;
                                msz[k] = msz[k] + 1;
                            end
                        end
                    end
                end
                if (clr_err) begin
                    movf[k] = 1'b0;
                    munf[k] = 1'b0;
                end
                movf[k] = movf[k] | ovf_set;
                munf[k] = munf[k] | unf_set;
            end
        end
    endtask

    // Per-cycle comparison of every DUT against its model.
    always @(negedge clk) begin
        if (started && reset) begin
            for (int k = 0; k < NDUT; k++) begin
                chk("rd_data", k, o_data[k], mrd[k]);
                chk("rd_valid", k, 32'(o_val[k]), 32'(mval[k]));
                chk("count", k, 32'(o_cnt[k]), 32'(msz[k]));
                chk("empty", k, 32'(o_emp[k]), 32'(msz[k] == 0));
                chk("full", k, 32'(o_full[k]), 32'(msz[k] == DEP[k]));
                chk("almost_empty", k, 32'(o_ae[k]), 32'(msz[k] <= 1));
                chk("almost_full", k, 32'(o_af[k]), 32'(msz[k] >= DEP[k] - 2));
                chk("overflow", k, 32'(o_ovf[k]), 32'(movf[k]));
                chk("underflow", k, 32'(o_unf[k]), 32'(munf[k]));
            end
        end
    end

    task automatic cyc(input logic f, input logic we, input logic [31:0] wd, input logic re, input logic ce);
        flush   = f;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clr_err = ce;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_count", k, 32'(o_cnt[k]), 32'd0);
            chk("rst_empty", k, 32'(o_emp[k]), 32'd1);
            chk("rst_ae", k, 32'(o_ae[k]), 32'd1);
            chk("rst_af", k, 32'(o_af[k]), 32'd0);
            chk("rst_data", k, o_data[k], 32'd0);
        end
        reset   = 1'b1;
        started = 1'b1;

        // Basic ordering and one-cycle read latency.
        cyc(1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h22, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h33, 1'b0, 1'b0);
        chk("t1_count3", 0, 32'(o_cnt[0]), 32'd3);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t1_rd0", 0, o_data[0], 32'h11);
        chk("t1_val0", 0, 32'(o_val[0]), 32'd1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t1_rd1", 0, o_data[0], 32'h22);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t1_rd2", 0, o_data[0], 32'h33);
        chk("t1_empty", 0, 32'(o_emp[0]), 32'd1);

        // Seventeen writes: overwrite vs drop policy.
        for (int i = 0; i <= 16; i++) cyc(1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
        chk("t2_cnt_ovw", 0, 32'(o_cnt[0]), 32'd16);
        chk("t2_ovf_ovw", 0, 32'(o_ovf[0]), 32'd1);
        chk("t2_ovf_drop", 1, 32'(o_ovf[1]), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            if (i == 0) begin
                chk("t2_first_ovw", 0, o_data[0], 32'd1);
                chk("t2_first_drop", 1, o_data[1], 32'd0);
            end
            if (i == 15) begin
                chk("t2_last_ovw", 0, o_data[0], 32'd16);
                chk("t2_last_drop", 1, o_data[1], 32'd15);
            end
        end
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Empty read, error clear, and set-wins-over-clear.
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t3_empty_data", 0, o_data[0], 32'hFFFF_FFFF);
        chk("t3_empty_val", 0, 32'(o_val[0]), 32'd0);
        chk("t3_unf", 0, 32'(o_unf[0]), 32'd1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("t3_unf_clr", 0, 32'(o_unf[0]), 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("t3_unf_setwins", 0, 32'(o_unf[0]), 32'd1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Full FIFO with simultaneous read and write across pointer wrap.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 32'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 32'(200 + i), 1'b1, 1'b0);
            if (i == 0) begin
                chk("t4_first16", 0, o_data[0], 32'd100);
                chk("t4_first5", 2, o_data[2], 32'd111);
            end
            if (i == 5)  chk("t4_wrap5", 2, o_data[2], 32'd200);
            if (i == 16) chk("t4_wrap16", 0, o_data[0], 32'd200);
        end
        chk("t4_cnt", 0, 32'(o_cnt[0]), 32'd16);
        chk("t4_no_ovf", 0, 32'(o_ovf[0]), 32'd0);

        // Flush beats a same-cycle write.
        cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 32'(300 + i), 1'b0, 1'b0);
        chk("t5_cnt10", 0, 32'(o_cnt[0]), 32'd10);
        cyc(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
        chk("t5_flush_cnt", 0, 32'(o_cnt[0]), 32'd0);
        chk("t5_flush_empty", 0, 32'(o_emp[0]), 32'd1);
        chk("t5_flush_val", 0, 32'(o_val[0]), 32'd0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 32'(400 + i), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'd500, 1'b1, 1'b0);
        flush   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 32'd600;
        rd_en   = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("t6_rst_cnt", k, 32'(o_cnt[k]), 32'd0);
            chk("t6_rst_empty", k, 32'(o_emp[k]), 32'd1);
            chk("t6_rst_data", k, o_data[k], 32'd0);
            chk("t6_rst_val", k, 32'(o_val[k]), 32'd0);
            chk("t6_rst_ovf", k, 32'(o_ovf[k]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 32'h0000_00AB, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t6_after_rst", 0, o_data[0], 32'h0000_00AB);
        cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
